pkt_fifo: RTL and testbench
===========================

# pkt_fifo

Single-clock packet FIFO with commit/rollback semantics for the tunnel datapath. Write side stages a packet word by word; the packet becomes visible to the read side only when its end-of-packet word is accepted. The write side can abort a partly written packet, and overflowing packets are discarded automatically. It sits between the packet parser/crypto stage and the egress framer, where a truncated or rejected packet must never reach the reader.

## Interface
- `ASIZE`, 3: address bits; depth = 2**ASIZE words.
- `DSIZE`, 16: data width.
- `AFULL_LVL`, 2**ASIZE-2: `almost_full` asserts when occupancy >= this value.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `wreq` in 1: write request; accepted when `!full`.
- `wdata` in DSIZE: write data.
- `weop` in 1: qualifies `wdata` as the last word of the packet.
- `wdrop` in 1: abort the uncommitted packet.
- `full` out 1: occupancy == depth, counting staged plus committed words.
- `almost_full` out 1: occupancy >= AFULL_LVL.
- `overflow` out 1: one-cycle pulse when a packet is auto-dropped.
- `rreq` in 1: read request; accepted when `!empty`.
- `rdata` out DSIZE: read data.
- `reop` out 1: end-of-packet flag for `rdata`.
- `rvalid` out 1: `rdata`/`reop` valid.
- `empty` out 1: no committed word is available.
- `pkt_cnt` out ASIZE+1: number of committed packets not yet fully read.

## Operation
- Storage: DEPTH × (DSIZE+1) array; `weop` is stored alongside the data.
- Pointers are ASIZE+1 bits, binary, and wrap naturally:
  - `wptr`: speculative write pointer.
  - `cptr`: commit pointer.
  - `rptr`: read pointer.
- Occupancy = `wptr - rptr`, modulo 2**(ASIZE+1).
- `full` = (occupancy == DEPTH).
- `empty` = (`rptr == cptr`).
- Accepted write (`wreq && !full && !wdrop && !drop_pend`): store the word at `wptr[ASIZE-1:0]` and increment `wptr`. If `weop` is set, `cptr` takes `wptr+1` and `pkt_cnt` increments.
- `wdrop`: `wptr` takes `cptr`. A `wreq` in the same cycle is discarded. Has no effect if nothing is staged.
- Overflow: `wreq && full` sets internal `drop_pend`.
  - While `drop_pend` is set, writes are ignored.
  - On the first `wreq && weop`, or on `wdrop`: `wptr` takes `cptr`, `drop_pend` clears, and `overflow` pulses.
  - If the whole FIFO is committed data, rollback frees nothing; the packet is still discarded.
- Accepted read (`rreq && !empty`): increment `rptr`. Reading a word whose stored eop is set decrements `pkt_cnt`.
- A commit and an eop read in the same cycle leave `pkt_cnt` unchanged.
- The read side never sees uncommitted words. `wdrop` during reads affects only the staged region.
- Reset: pointers 0, `drop_pend` 0, `empty` 1. All other outputs 0, including `rdata`, `reop`, `rvalid`, `overflow` and `pkt_cnt`.

## Timing
- `full`, `almost_full` and `empty` are decoded from registered pointers only, with no combinational path from `wreq`/`rreq`. They update the cycle after the causing edge.
- Write-to-read latency: an eop accepted at edge N gives `empty`=0 after edge N. The first read is accepted at edge N+1 at the earliest.
- Default read mode: `rdata`/`reop`/`rvalid` are registered and appear one cycle after an accepted `rreq`. `rvalid` is low on cycles without an accepted read. `rdata` holds its last value.
- Back-to-back reads and writes every cycle are supported. Simultaneous read and write at `full` is not accepted for the write, because `full` is from pointer registers.
- Reset asserted mid-packet clears everything immediately and asynchronously. Staged and committed data are lost.

## Configuration
- `PKT_FIFO_FWFT_EN` defined: first-word fall-through mode.
  - `rdata`/`reop` = `mem[rptr]` combinationally.
  - `rvalid` = `!empty`.
  - `rreq` acts as pop/acknowledge with zero latency.
- `PKT_FIFO_FWFT_EN` undefined: registered read as in Timing.
- Write-side behaviour is identical in both modes.

## Structure
- Shared package `pkt_fifo_pkg`:
  - pointer-difference and occupancy function;
  - a `fifo_word_t` typedef ({eop, data}) parameterised via DSIZE in the module.
- One sub-module `pkt_fifo_ram`: simple dual-port array, synchronous write, with a registered read port or an asynchronous one under FWFT.
- The control logic stays in `pkt_fifo`.

## Test plan
1. Reset, then write a 3-word packet 0x11,0x22,0x33 with eop on 0x33 → `empty` stays 1 until the cycle after the eop write. Then 3 reads return 0x11,0x22,0x33 with `reop`=0,0,1. `pkt_cnt` goes 1→0.
2. Write 2 words, then assert `wdrop` → `empty` stays 1 and occupancy returns to 0. The next packet 0xAA(eop) reads back alone.
3. ASIZE=3: write a 9-word packet → `full` after 8 words, the 9th word with eop triggers `overflow` for one cycle, and the FIFO ends empty with `pkt_cnt`=0.
4. Commit 1-word packet A, then write an eop word of packet B in the same cycle that A is read → `pkt_cnt` stays 1 and B reads next.
5. Stream 20 one-word packets with continuous `wreq`/`rreq` → the data order is preserved across pointer wrap with no loss, and `almost_full` never asserts.
6. Assert `rst` low mid-packet with committed data present → all outputs take their reset values at once. After release, `empty`=1 and `full`=0.

Source files
------------

// File: rtl/pkt_fifo_pkg.sv
// Shared types and helpers for the packet FIFO.
// Contents: write-side state enum and the modular pointer-difference helper
// used for occupancy.
package pkt_fifo_pkg;

  // Write-side state: passing words through, or discarding an overflowed packet.
  typedef enum logic {
    WR_PASS = 1'b0,
    WR_DROP = 1'b1
  } wr_state_t;

  // Modular difference a - b over the low 'w' bits.
  // The pointers are at most 32 bits wide, so callers widen their pointers
  // into the 32-bit arguments and narrow the result back down.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned w);
    logic [31:0] mask;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port storage array for pkt_fifo.
// The write port is synchronous.
// The read port is registered by default; when PKT_FIFO_FWFT_EN is defined it
// becomes an asynchronous read so the head word falls through.
module pkt_fifo_ram #(
  parameter int AW = 3,
  parameter int W  = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  // Synchronous write port; the array itself carries no reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef PKT_FIFO_FWFT_EN
  // Fall-through read: the addressed word is always presented.
  assign rdata = mem[raddr];

  logic unused_rd_ctrl;
  assign unused_rd_ctrl = &{1'b0, re, rst};
`else
  // Registered read port: rdata updates only on an accepted read and holds otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/pkt_fifo.sv
// Single-clock packet FIFO with commit/rollback.
// Words are staged behind a commit pointer and become readable only once the
// end-of-packet word is accepted.
// The writer can abort a staged packet with wdrop, and a packet that runs into
// a full FIFO is discarded automatically; the overflow output pulses when that
// happens.
// Macro PKT_FIFO_FWFT_EN selects first-word fall-through reads; the default
// build uses registered reads.
//
// Handshake: a write is accepted on a cycle with wreq && !full && !wdrop while
// no overflowed packet is being discarded. A read is accepted on a cycle with
// rreq && !empty. Requests made while full/empty are simply not taken; nothing
// stalls.
//
// wr_state is a debug output that exposes the write-side FSM: 1 while an
// overflowed packet is being discarded.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int ASIZE     = 3,
  parameter int DSIZE     = 16,
  parameter int AFULL_LVL = 2**ASIZE - 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wreq,
  input  logic [DSIZE-1:0] wdata,
  input  logic             weop,
  input  logic             wdrop,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  input  logic             rreq,
  output logic [DSIZE-1:0] rdata,
  output logic             reop,
  output logic             rvalid,
  output logic             empty,
  output logic [ASIZE:0]   pkt_cnt,
  output logic             wr_state
);

  localparam int DEPTH = 2**ASIZE;
  localparam int PW    = ASIZE + 1;

  typedef struct packed {
    logic             eop;
    logic [DSIZE-1:0] data;
  } fifo_word_t;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] cptr_q, cptr_d;
  logic [PW-1:0] rptr_q;
  logic [PW-1:0] occ;
  logic [PW-1:0] pkt_cnt_q;
  wr_state_t     state_q, state_d;
  logic          ovf_d, ovf_q;
  logic          wr_acc, rd_acc, commit, rd_eop;
  logic [DEPTH-1:0] eop_map;
  fifo_word_t    wr_word, rd_word;

  // Status flags are decoded from registered pointers only.
  assign occ         = PW'(ptr_diff(32'(wptr_q), 32'(rptr_q), PW));
  assign full        = (occ == PW'(DEPTH));
  assign almost_full = (int'(occ) >= AFULL_LVL);
  assign empty       = (rptr_q == cptr_q);

  assign wr_acc = wreq && !full && !wdrop && (state_q == WR_PASS);
  assign commit = wr_acc && weop;
  assign rd_acc = rreq && !empty;
  // eop_map shadows the stored eop bits so the packet count can react in the
  // same cycle as the read, even though the array's read port is registered.
  assign rd_eop = rd_acc && eop_map[rptr_q[ASIZE-1:0]];

  // Write-side next state: accept/commit, abort, and overflow discard.
  always_comb begin
    wptr_d  = wptr_q;
    cptr_d  = cptr_q;
    state_d = state_q;
    ovf_d   = 1'b0;
    case (state_q)
      WR_PASS: begin
        if (wdrop) begin
          wptr_d = cptr_q;
        end else if (wr_acc) begin
          wptr_d = wptr_q + 1'b1;
          if (weop) cptr_d = wptr_q + 1'b1;
        end else if (wreq && full) begin
          // A full FIFO ends the packet now if this word is its last,
          // otherwise the rest of the packet is swallowed until its eop.
          if (weop) begin
            wptr_d = cptr_q;
            ovf_d  = 1'b1;
          end else begin
            state_d = WR_DROP;
          end
        end
      end
      WR_DROP: begin
        if (wdrop || (wreq && weop)) begin
          wptr_d  = cptr_q;
          ovf_d   = 1'b1;
          state_d = WR_PASS;
        end
      end
      default: state_d = WR_PASS;
    endcase
  end

  // Pointer, FSM and overflow-pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      cptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= WR_PASS;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      cptr_q  <= cptr_d;
      state_q <= state_d;
      ovf_q   <= ovf_d;
      if (rd_acc) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Committed-packet counter; a commit and an eop read in one cycle cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
    end else begin
      case ({commit, rd_eop})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + 1'b1;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - 1'b1;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
    end
  end

  // Shadow copy of each slot's eop bit, written alongside the array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        eop_map <= '0;
    else if (wr_acc) eop_map[wptr_q[ASIZE-1:0]] <= weop;
  end

  assign wr_word.eop  = weop;
  assign wr_word.data = wdata;

  pkt_fifo_ram #(
    .AW (ASIZE),
    .W  (DSIZE + 1)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr_q[ASIZE-1:0]),
    .wdata (wr_word),
    .re    (rd_acc),
    .raddr (rptr_q[ASIZE-1:0]),
    .rdata (rd_word)
  );

`ifdef PKT_FIFO_FWFT_EN
  // Head word is presented whenever one is committed; rreq just pops it.
  // Outputs read as zero while empty, so they match their reset values.
  assign rvalid = !empty;
  assign rdata  = empty ? '0   : rd_word.data;
  assign reop   = empty ? 1'b0 : rd_word.eop;
`else
  logic rvalid_q;

  // rvalid marks the cycle after each accepted read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rvalid_q <= 1'b0;
    else      rvalid_q <= rd_acc;
  end

  assign rvalid = rvalid_q;
  assign rdata  = rd_word.data;
  assign reop   = rd_word.eop;
`endif

  assign overflow = ovf_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign wr_state = (state_q == WR_DROP);

endmodule

// File: tb/tb_pkt_fifo.sv
// Self-checking bench for pkt_fifo in the default registered-read build.
// Inputs change 1 ns after a rising edge and are taken at the next edge;
// outputs are sampled 1 ns after that edge.
module tb_pkt_fifo;

  localparam int ASIZE = 3;
  localparam int DSIZE = 16;

  logic             clk;
  logic             rst;
  logic             wreq, weop, wdrop, rreq;
  logic [DSIZE-1:0] wdata;
  logic             full, almost_full, overflow, reop, rvalid, empty, wr_state;
  logic [DSIZE-1:0] rdata;
  logic [ASIZE:0]   pkt_cnt;

  int tests_run;
  int tests_failed;

  logic [DSIZE-1:0] exp_q[$];

  pkt_fifo #(.ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
    .clk         (clk),
    .rst         (rst),
    .wreq        (wreq),
    .wdata       (wdata),
    .weop        (weop),
    .wdrop       (wdrop),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .rreq        (rreq),
    .rdata       (rdata),
    .reop        (reop),
    .rvalid      (rvalid),
    .empty       (empty),
    .pkt_cnt     (pkt_cnt),
    .wr_state    (wr_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             wreq, weop, wdrop, rreq;
    logic [DSIZE-1:0] wdata;
    logic             e_empty, e_full, e_af, e_ovf, e_rvalid, e_reop;
    logic [DSIZE-1:0] e_rdata;
    logic [ASIZE:0]   e_pkt;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic wr, input logic [DSIZE-1:0] d, input logic eop,
                       input logic drp, input logic rd);
    wreq  = wr;
    wdata = d;
    weop  = eop;
    wdrop = drp;
    rreq  = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic vec_t mk(input logic wr, input logic eop, input logic drp,
                              input logic rd, input logic [DSIZE-1:0] d,
                              input logic e_mt, input logic e_ovf, input logic e_rv,
                              input logic e_reop, input logic [DSIZE-1:0] e_rd,
                              input logic [ASIZE:0] e_pkt);
    vec_t v;
    v.wreq = wr; v.weop = eop; v.wdrop = drp; v.rreq = rd; v.wdata = d;
    v.e_empty = e_mt; v.e_full = 1'b0; v.e_af = 1'b0; v.e_ovf = e_ovf;
    v.e_rvalid = e_rv; v.e_reop = e_reop; v.e_rdata = e_rd; v.e_pkt = e_pkt;
    return v;
  endfunction

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst = 1'b0;
    idle();

    // Table: wr eop drop rd wdata | empty ovf rvalid reop rdata pkt_cnt
    // Packet 0x11,0x22,0x33 then three reads
    vecs[0]  = mk(1, 0, 0, 0, 16'h0011, 1, 0, 0, 0, 16'h0000, 0);
    vecs[1]  = mk(1, 0, 0, 0, 16'h0022, 1, 0, 0, 0, 16'h0000, 0);
    vecs[2]  = mk(1, 1, 0, 0, 16'h0033, 0, 0, 0, 0, 16'h0000, 1);
    vecs[3]  = mk(0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 16'h0011, 1);
    vecs[4]  = mk(0, 0, 0, 1, 16'h0000, 0, 0, 1, 0, 16'h0022, 1);
    vecs[5]  = mk(0, 0, 0, 1, 16'h0000, 1, 0, 1, 1, 16'h0033, 0);
    vecs[6]  = mk(0, 0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    // Stage two words, abort (with a discarded wreq), then 0xAA alone
    vecs[7]  = mk(1, 0, 0, 0, 16'h0044, 1, 0, 0, 0, 16'h0000, 0);
    vecs[8]  = mk(1, 0, 0, 0, 16'h0055, 1, 0, 0, 0, 16'h0000, 0);
    vecs[9]  = mk(1, 0, 1, 0, 16'h0066, 1, 0, 0, 0, 16'h0000, 0);
    vecs[10] = mk(1, 1, 0, 0, 16'h00AA, 0, 0, 0, 0, 16'h0000, 1);
    vecs[11] = mk(0, 0, 0, 1, 16'h0000, 1, 0, 1, 1, 16'h00AA, 0);
    vecs[12] = mk(0, 0, 0, 1, 16'h0000, 1, 0, 0, 0, 16'h0000, 0);
    // Commit A, then commit B while A is read
    vecs[13] = mk(1, 1, 0, 0, 16'h00A1, 0, 0, 0, 0, 16'h0000, 1);
    vecs[14] = mk(1, 1, 0, 1, 16'h00B1, 0, 0, 1, 1, 16'h00A1, 1);
    vecs[15] = mk(0, 0, 0, 1, 16'h0000, 1, 0, 1, 1, 16'h00B1, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty",  32'(empty), 32'd1);
    chk("rst_full",   32'(full), 32'd0);
    chk("rst_af",     32'(almost_full), 32'd0);
    chk("rst_ovf",    32'(overflow), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata",  32'(rdata), 32'd0);
    chk("rst_pkt",    32'(pkt_cnt), 32'd0);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].wreq, vecs[i].wdata, vecs[i].weop, vecs[i].wdrop, vecs[i].rreq);
      step();
      chk($sformatf("v%0d_flags", i),
          32'({empty, full, almost_full, overflow, rvalid}),
          32'({vecs[i].e_empty, vecs[i].e_full, vecs[i].e_af, vecs[i].e_ovf, vecs[i].e_rvalid}));
      chk($sformatf("v%0d_pkt", i), 32'(pkt_cnt), 32'(vecs[i].e_pkt));
      if (vecs[i].e_rvalid)
        chk($sformatf("v%0d_data", i), 32'({reop, rdata}), 32'({vecs[i].e_reop, vecs[i].e_rdata}));
    end
    idle();
    step();

    // 9-word packet into an 8-deep FIFO, eop on the overflowing word
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DSIZE'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
      step();
      chk($sformatf("ovfA_full%0d", i), 32'(full), 32'(i == 7));
      chk($sformatf("ovfA_af%0d", i), 32'(almost_full), 32'(i >= 5));
      chk($sformatf("ovfA_empty%0d", i), 32'(empty), 32'd1);
    end
    drive(1'b1, 16'h0108, 1'b1, 1'b0, 1'b0);
    step();
    chk("ovfA_pulse", 32'(overflow), 32'd1);
    chk("ovfA_after", 32'({empty, full, almost_full}), 32'b100);
    chk("ovfA_pkt", 32'(pkt_cnt), 32'd0);
    idle();
    step();
    chk("ovfA_pulse_end", 32'(overflow), 32'd0);

    // Overflow with the eop arriving two words after full
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DSIZE'(16'h0200 + i), 1'b0, 1'b0, 1'b0);
      step();
    end
    chk("ovfB_full", 32'(full), 32'd1);
    drive(1'b1, 16'h0208, 1'b0, 1'b0, 1'b0);
    step();
    chk("ovfB_drop_state", 32'({wr_state, overflow}), 32'b10);
    drive(1'b1, 16'h0209, 1'b0, 1'b0, 1'b0);
    step();
    chk("ovfB_still_drop", 32'({wr_state, overflow, full}), 32'b101);
    drive(1'b1, 16'h020A, 1'b1, 1'b0, 1'b0);
    step();
    chk("ovfB_pulse", 32'({wr_state, overflow, full, empty}), 32'b0101);
    drive(1'b1, 16'h0077, 1'b1, 1'b0, 1'b0);
    step();
    chk("ovfB_recover", 32'({empty, pkt_cnt}), 32'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step();
    chk("ovfB_read", 32'({rvalid, reop, rdata}), 32'({1'b1, 1'b1, 16'h0077}));
    chk("ovfB_clean", 32'({empty, pkt_cnt}), 32'h10);
    idle();
    step();

    // Streaming 20 one-word packets across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DSIZE'(16'h0300 + i), 1'b1, 1'b0, 1'b1);
      exp_q.push_back(DSIZE'(16'h0300 + i));
      step();
      chk($sformatf("strm_af%0d", i), 32'(almost_full), 32'd0);
      if (rvalid) begin
        if (exp_q.size() == 0) chk("strm_extra", 32'(rdata), 32'hFFFF_FFFF);
        else chk($sformatf("strm_data%0d", i), 32'({reop, rdata}), 32'({1'b1, exp_q.pop_front()}));
      end
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      step();
      if (rvalid) begin
        if (exp_q.size() == 0) chk("strm_extra", 32'(rdata), 32'hFFFF_FFFF);
        else chk($sformatf("strm_drain%0d", i), 32'({reop, rdata}), 32'({1'b1, exp_q.pop_front()}));
      end
    end
    chk("strm_left", 32'(exp_q.size()), 32'd0);
    chk("strm_end", 32'({empty, pkt_cnt}), 32'h10);
    idle();
    step();

    // Asynchronous reset mid-packet with committed data and a live read
    drive(1'b1, 16'h0061, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0062, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'h0063, 1'b0, 1'b0, 1'b1);
    step();
    chk("pre_rst", 32'({rvalid, rdata, pkt_cnt}), 32'({1'b1, 16'h0061, 4'd1}));
    idle();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_flags", 32'({empty, full, almost_full, overflow, rvalid, reop}), 32'b100000);
    chk("arst_rdata", 32'(rdata), 32'd0);
    chk("arst_pkt", 32'(pkt_cnt), 32'd0);
    step();
    rst = 1'b1;
    step();
    chk("post_rst", 32'({empty, full, pkt_cnt}), 32'h20);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
